// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin queue arbiter.
// Holds the FSM state encoding and the requester index width function.
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search over the request vector.
// The search begins one past the previous winner and wraps at NREQ.
module rr_priority_picker
    import rr_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [IW-1:0]   winner,
    output logic            any_req
);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last_grant) + k) % NREQ);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/rr_queue_arbiter.sv
// Round-robin arbiter feeding one downstream queue with bounded bursts.
// Grantee data passes through combinationally; each new grant costs one idle cycle.
module rr_queue_arbiter
    import rr_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [NREQ*WIDTH-1:0]   recv_msg,
    input  logic [NREQ-1:0]         recv_val,
    output logic [NREQ-1:0]         recv_rdy,
    output logic [WIDTH-1:0]        send_msg,
    output logic                    send_val,
    input  logic                    send_rdy,
    output logic [$clog2(NREQ)-1:0] send_src
);

    localparam int IW = idx_w(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t                   state;
    logic [IW-1:0]                grant;
    logic [IW-1:0]                last_grant;
    logic [BW-1:0]                beat_cnt;
    logic [IW-1:0]                winner;
    logic                         any_req;
    logic                         xfer;
    logic                         last_beat;
    logic [NREQ-1:0][WIDTH-1:0]   msgs;

    assign msgs = recv_msg;

    rr_priority_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req        (recv_val),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    // Outputs are gated by reset so nothing transfers in a reset cycle.
    always_comb begin
        send_val = 1'b0;
        recv_rdy = '0;
        send_msg = msgs[grant];
        if (state == GRANT && !reset) begin
            send_val        = recv_val[grant];
            recv_rdy[grant] = send_rdy;
        end
    end

    assign send_src  = grant;
    assign xfer      = send_val && send_rdy;
    assign last_beat = (beat_cnt == BW'(MAX_BURST - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IW'(NREQ - 1);
            beat_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en && any_req) begin
                        grant      <= winner;
                        last_grant <= winner;
                        beat_cnt   <= '0;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (!recv_val[grant] || (xfer && last_beat)) begin
                        state <= IDLE;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_queue_arbiter.sv
// Self-checking bench: behavioural grant model compared every cycle,
// plus directed scenarios with hand-computed transfer sequences.
module tb_rr_queue_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int MB    = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  en = 1'b0;
    logic [NREQ*WIDTH-1:0] recv_msg = '0;
    logic [NREQ-1:0]       recv_val = '0;
    logic [NREQ-1:0]       recv_rdy;
    logic [WIDTH-1:0]      send_msg;
    logic                  send_val;
    logic                  send_rdy = 1'b0;
    logic [1:0]            send_src;

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;
    int xq[$];

    // Model state: busy flag, owner, previous winner, beats delivered.
    int m_busy = 0;
    int m_owner = 0;
    int m_last = NREQ - 1;
    int m_beats = 0;

    rr_queue_arbiter #(
        .WIDTH     (WIDTH),
        .NREQ      (NREQ),
        .MAX_BURST (MB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .recv_msg (recv_msg),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .send_msg (send_msg),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .send_src (send_src)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            m_busy  = 0;
            m_owner = 0;
            m_last  = NREQ - 1;
            m_beats = 0;
        end else if (m_busy == 0) begin
            if (en && recv_val != '0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int c;
                    c = (m_last + k) % NREQ;
                    if (m_busy == 0 && recv_val[c]) begin
                        m_owner = c;
                        m_busy  = 1;
                    end
                end
                m_last  = m_owner;
                m_beats = 0;
            end
        end else begin
            if (!recv_val[m_owner]) begin
                m_busy = 0;
            end else if (send_rdy) begin
                m_beats++;
                if (m_beats == MB) m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic             e_val;
        logic [NREQ-1:0]  e_rdy;
        logic [WIDTH-1:0] e_msg;
        if (checking) begin
            e_val = !reset && m_busy == 1 && recv_val[m_owner];
            e_rdy = '0;
            if (!reset && m_busy == 1 && send_rdy) e_rdy[m_owner] = 1'b1;
            e_msg = WIDTH'(recv_msg >> (WIDTH * m_owner));
            total++;
            if (send_val !== e_val) begin
                bad++;
                $display("FAIL cyc_send_val got=%0b exp=%0b t=%0t", send_val, e_val, $time);
            end
            total++;
            if (recv_rdy !== e_rdy) begin
                bad++;
                $display("FAIL cyc_recv_rdy got=%b exp=%b t=%0t", recv_rdy, e_rdy, $time);
            end
            if (e_val) begin
                total++;
                if (send_src !== 2'(m_owner)) begin
                    bad++;
                    $display("FAIL cyc_send_src got=%0d exp=%0d t=%0t", send_src, m_owner, $time);
                end
                total++;
                if (send_msg !== e_msg) begin
                    bad++;
                    $display("FAIL cyc_send_msg got=%h exp=%h t=%0t", send_msg, e_msg, $time);
                end
            end
            if (send_val === 1'b1 && send_rdy) xq.push_back(int'(send_src));
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Expected sequence packed one element per nibble, element 0 lowest.
    task automatic check_log(input string name, input int n, input logic [127:0] seq);
        chk({name, "_count"}, xq.size(), n);
        for (int j = 0; j < n && j < xq.size(); j++) begin
            chk($sformatf("%s_xfer%0d", name, j), xq[j], int'(seq[4*j +: 4]));
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            recv_msg = 32'($urandom);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        recv_val = '0;
        en = 1'b1;
        send_rdy = 1'b1;
        cycles(2);
        reset = 1'b0;
        checking = 1'b1;
        @(negedge clk);
        chk("rst_send_val", int'(send_val), 0);
        chk("rst_recv_rdy", int'(recv_rdy), 0);
        chk("rst_send_src", int'(send_src), 0);
        xq.delete();
    endtask

    initial begin
        // Alternating pair: 0, 2, 0 with four beats each.
        do_reset();
        recv_val = 4'b0101;
        cycles(15);
        recv_val = '0;
        cycles(3);
        check_log("pair", 12, 128'h0000_2222_0000);

        // All valid: strict rotation 0,1,2,3,0.
        do_reset();
        recv_val = 4'b1111;
        cycles(25);
        recv_val = '0;
        cycles(3);
        check_log("all", 20, 128'h0000_3333_2222_1111_0000);

        // Downstream stall mid-burst on requester 1.
        do_reset();
        recv_val = 4'b0010;
        cycles(2);
        send_rdy = 1'b0;
        @(negedge clk);
        chk("stall_send_val", int'(send_val), 1);
        chk("stall_recv_rdy", int'(recv_rdy), 0);
        chk("stall_src", int'(send_src), 1);
        cycles(3);
        send_rdy = 1'b1;
        cycles(3);
        recv_val = '0;
        cycles(3);
        check_log("stall", 4, 128'h1111);

        // Grantee 1 drops after two beats; 3 is next.
        do_reset();
        recv_val = 4'b1010;
        cycles(3);
        recv_val = 4'b1000;
        @(negedge clk);
        chk("drop_send_val", int'(send_val), 0);
        cycles(6);
        recv_val = '0;
        cycles(3);
        check_log("drop", 6, 128'h33_3311);

        // Enable dropped mid-burst: burst completes, then no new grant.
        do_reset();
        recv_val = 4'b1111;
        cycles(2);
        en = 1'b0;
        cycles(8);
        @(negedge clk);
        chk("en_off_idle", int'(send_val), 0);
        check_log("en_off", 4, 128'h0000);
        xq.delete();
        en = 1'b1;
        cycles(5);
        recv_val = '0;
        cycles(3);
        check_log("en_on", 4, 128'h1111);

        // Reset at beat 2 of the grant to requester 1.
        do_reset();
        recv_val = 4'b1111;
        cycles(8);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_send_val_during", int'(send_val), 0);
        cycles(1);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_send_val", int'(send_val), 0);
        chk("midrst_recv_rdy", int'(recv_rdy), 0);
        xq.delete();
        cycles(5);
        recv_val = '0;
        cycles(3);
        check_log("midrst", 4, 128'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_queue_arbiter.md
RR_QUEUE_ARBITER -- requirements
Module: rr_queue_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: message width in bits.
REQ-002 Parameter NREQ, default 4: number of requesters, range 2..8.
REQ-003 Parameter MAX_BURST, default 4: maximum transfers per grant, range 1..16.
REQ-004 The block SHALL have one clock and SHALL use a synchronous, active-high reset; the ports SHALL be clk and reset.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 en  input  1  arbitration enable; low blocks new grants only.
REQ-008 recv_msg  input  NREQ*WIDTH  requester messages; slice i is bits [i*WIDTH +: WIDTH].
REQ-009 recv_val  input  NREQ  per-requester valid.
REQ-010 recv_rdy  output  NREQ  per-requester ready.
REQ-011 send_msg  output  WIDTH  message to the downstream queue.
REQ-012 send_val  output  1  downstream valid.
REQ-013 send_rdy  input  1  downstream ready.
REQ-014 send_src  output  $clog2(NREQ)  index of the current grantee; valid whenever send_val is 1.

Function
REQ-015 The FSM SHALL have two states: IDLE and GRANT.
REQ-016 In IDLE: send_val=0 and recv_rdy=0.
REQ-017 In IDLE with en=1 and any recv_val bit set: pick the winner by round-robin, starting the search at last_grant+1 mod NREQ; register it in grant; set last_grant=winner; clear beat_cnt; go to GRANT next cycle. This gives a one-cycle arbitration bubble.
REQ-018 In IDLE with en=0 or recv_val=0: stay in IDLE; no register changes.
REQ-019 In GRANT, outputs SHALL be combinational pass-through of the grantee: send_val=recv_val[grant], send_msg=recv_msg slice grant, recv_rdy[grant]=send_rdy, all other recv_rdy bits 0.
REQ-020 A transfer is send_val && send_rdy; each transfer increments beat_cnt.
REQ-021 GRANT SHALL go to IDLE next cycle when either:
  - a transfer occurs with beat_cnt==MAX_BURST-1; or
  - recv_val[grant]==0.
REQ-022 Otherwise GRANT SHALL hold, including when send_rdy=0 (no beat counted).
REQ-023 The block SHALL NOT re-arbitrate in the same cycle as a release; the next grant always costs one IDLE cycle.
REQ-024 en=0 during GRANT SHALL NOT truncate the burst.
REQ-025 recv_msg SHALL NOT be modified or buffered; latency is 0 cycles in GRANT.
REQ-026 beat_cnt SHALL be $clog2(MAX_BURST+1) bits wide and SHALL never exceed MAX_BURST-1 at a clock edge.
REQ-027 last_grant wraps from NREQ-1 to 0.
REQ-028 A single persistent requester SHALL be re-granted after each release.
REQ-029 Fairness: with all requesters continuously valid, each requester SHALL receive exactly one grant per NREQ grants.

Reset
REQ-030 On reset=1 at a clock edge: state=IDLE, grant=0, last_grant=NREQ-1 (requester 0 has first priority), beat_cnt=0.
REQ-031 During and immediately after reset: send_val=0, recv_rdy=0, send_src=0.
REQ-032 Reset mid-burst SHALL abandon the burst; no transfer is reported in the reset cycle.

Structure
REQ-033 A shared package rr_arb_pkg SHALL hold the FSM state enum (IDLE, GRANT) and a localparam function for the index width.
REQ-034 The round-robin search SHALL be a combinational sub-module rr_priority_picker with:
  - inputs: req vector and last_grant;
  - outputs: winner index and any_req.
REQ-035 The FSM, beat counter and output muxing SHALL reside in rr_queue_arbiter.

Verification
REQ-036 Reset, then recv_val=4'b0101 and send_rdy=1 held -> first grant goes to 0, then 2, then 0, with one IDLE cycle between grants and 4 transfers per grant.
REQ-037 recv_val=4'b1111 held, send_rdy=1 -> send_src sequence 0,1,2,3,0; each grant delivers 4 transfers.
REQ-038 Grant to 1, then send_rdy=0 for 3 cycles mid-burst -> grant holds, beat_cnt frozen, recv_rdy=4'b0000; the burst completes 4 transfers after send_rdy returns.
REQ-039 Grantee drops recv_val after 2 transfers -> IDLE next cycle; last_grant=grantee; the next winner is the following valid requester.
REQ-040 en=0 asserted at burst transfer 2 -> burst finishes all 4 transfers, then the block stays in IDLE with recv_val=4'b1111 until en=1.
REQ-041 reset pulsed during GRANT at beat 2 -> the next cycle shows send_val=0 and recv_rdy=0; the first grant after reset goes to requester 0.
